// File: rtl/pc_clk_pkg.sv
// Shared constants and the clk88 phase encoding for the 8088 board clock generator.
package pc_clk_pkg;

  localparam int PC_OSC_DIV  = 7;
  localparam int PC_OSC_HI   = 3;
  localparam int PC_RST_HOLD = 4;
  localparam int PC_VGA_HALF = 2;

  // Three OSC periods per clk88 period; clk88 is high only in PH_HI.
  typedef enum logic [1:0] {
    PH0   = 2'd0,
    PH1   = 2'd1,
    PH_HI = 2'd2
  } clk88_ph_e;

endpackage

// File: rtl/pc_sync2.sv
// Two-flop synchronizer for asynchronous level inputs; resets to 0.
module pc_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic s1_q, s2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/pc_clock_gen.sv
// 8088 board clock/ready/reset generator: OSC, clk88 (33% duty), PCLK, edge strobes,
// 8284-style READY and power-on RESET. Define PC_VGA_CLK_EN to generate vga_clk.
module pc_clock_gen
  import pc_clk_pkg::*;
#(
  parameter int OSC_DIV  = PC_OSC_DIV,
  parameter int OSC_HI   = PC_OSC_HI,
  parameter int RST_HOLD = PC_RST_HOLD,
  parameter int VGA_HALF = PC_VGA_HALF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pwr_good,
  input  logic rdy_wait_n,
  input  logic dma_wait_n,
  output logic osc,
  output logic clk88,
  output logic clk88_rise,
  output logic clk88_fall,
  output logic pclk,
  output logic ready,
  output logic reset,
  output logic vga_clk
);

  if (OSC_DIV < 2 || OSC_DIV > 15) begin : g_bad_div
    $error("pc_clock_gen: OSC_DIV out of range");
  end
  if (OSC_HI < 1 || OSC_HI > OSC_DIV - 1) begin : g_bad_hi
    $error("pc_clock_gen: OSC_HI out of range");
  end
  if (RST_HOLD < 1 || RST_HOLD > 255) begin : g_bad_hold
    $error("pc_clock_gen: RST_HOLD out of range");
  end
  if (VGA_HALF < 1 || VGA_HALF > 255) begin : g_bad_vga
    $error("pc_clock_gen: VGA_HALF out of range");
  end

  logic [3:0] osc_cnt_q, osc_cnt_d;
  clk88_ph_e  ph_q, ph_d;
  logic [7:0] hold_cnt_q;
  logic       osc_q, clk88_q, rise_q, fall_q, pclk_q, r1_q, ready_q, reset_q;
  logic       osc_tick, rise_now, fall_now, pg_s;

  pc_sync2 u_pg_sync (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .d_i    (pwr_good),
    .q_o    (pg_s)
  );

  assign osc_tick = (osc_cnt_q == 4'(OSC_DIV - 1));
  assign rise_now = osc_tick && (ph_q == PH1);
  assign fall_now = osc_tick && (ph_q == PH_HI);

  always_comb begin
    osc_cnt_d = osc_tick ? 4'd0 : osc_cnt_q + 4'd1;
    ph_d      = ph_q;
    if (osc_tick) begin
      case (ph_q)
        PH0:     ph_d = PH1;
        PH1:     ph_d = PH_HI;
        default: ph_d = PH0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      osc_cnt_q  <= 4'd0;
      ph_q       <= PH0;
      osc_q      <= 1'b0;
      clk88_q    <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      pclk_q     <= 1'b0;
      r1_q       <= 1'b0;
      ready_q    <= 1'b0;
      reset_q    <= 1'b1;
      hold_cnt_q <= 8'd0;
    end else begin
      osc_cnt_q <= osc_cnt_d;
      ph_q      <= ph_d;
      osc_q     <= (osc_cnt_d < 4'(OSC_HI));
      clk88_q   <= (ph_d == PH_HI);
      rise_q    <= rise_now;
      fall_q    <= fall_now;
      if (fall_now) pclk_q <= ~pclk_q;
      // READY: sample on the clk88 rise, present on the following fall.
      if (rise_now) r1_q    <= rdy_wait_n & dma_wait_n;
      if (fall_now) ready_q <= r1_q;
      if (!pg_s) begin
        hold_cnt_q <= 8'd0;
        reset_q    <= 1'b1;
      end else if (reset_q && fall_now) begin
        if (hold_cnt_q != 8'(RST_HOLD)) hold_cnt_q <= hold_cnt_q + 8'd1;
        if (hold_cnt_q == 8'(RST_HOLD - 1)) reset_q <= 1'b0;
      end
    end
  end

  assign osc        = osc_q;
  assign clk88      = clk88_q;
  assign clk88_rise = rise_q;
  assign clk88_fall = fall_q;
  assign pclk       = pclk_q;
  assign ready      = ready_q;
  assign reset      = reset_q;

`ifdef PC_VGA_CLK_EN
  logic [7:0] vga_cnt_q;
  logic       vga_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_cnt_q <= 8'd0;
      vga_q     <= 1'b0;
    end else if (vga_cnt_q == 8'(VGA_HALF - 1)) begin
      vga_cnt_q <= 8'd0;
      vga_q     <= ~vga_q;
    end else begin
      vga_cnt_q <= vga_cnt_q + 8'd1;
    end
  end

  assign vga_clk = vga_q;
`else
  assign vga_clk = 1'b0;
`endif

endmodule

// File: tb/tb_pc_clock_gen.sv
// Randomized bench for pc_clock_gen against an edge-count reference model.
module tb_pc_clock_gen;
  import pc_clk_pkg::*;

  localparam int OD = PC_OSC_DIV;
  localparam int OH = PC_OSC_HI;
  localparam int RH = PC_RST_HOLD;
  localparam int VH = PC_VGA_HALF;
  localparam int P  = 3 * OD;

  logic clk = 1'b0, reset_n = 1'b0, pwr_good = 1'b0, rdy = 1'b1, dma = 1'b1;
  logic osc, clk88, clk88_rise, clk88_fall, pclk, ready, reset, vga_clk;

  pc_clock_gen dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pwr_good   (pwr_good),
    .rdy_wait_n (rdy),
    .dma_wait_n (dma),
    .osc        (osc),
    .clk88      (clk88),
    .clk88_rise (clk88_rise),
    .clk88_fall (clk88_fall),
    .pclk       (pclk),
    .ready      (ready),
    .reset      (reset),
    .vga_clk    (vga_clk)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: n = clk edges since reset_n release; clocks follow from n directly.
  int n, m_hold;
  bit m_pg1, m_pgs, m_r1, m_ready, m_reset, pgs_old, m_fall, m_rise;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n = 0; m_pg1 = 0; m_pgs = 0; m_r1 = 0; m_ready = 0; m_reset = 1; m_hold = 0;
    end else begin
      n++;
      m_fall  = (n % P == 0);
      m_rise  = (n % P == 2 * OD);
      pgs_old = m_pgs;
      m_pgs   = m_pg1;
      m_pg1   = pwr_good;
      if (m_rise) m_r1 = rdy & dma;
      if (m_fall) m_ready = m_r1;
      if (!pgs_old) begin
        m_hold = 0; m_reset = 1;
      end else if (m_reset && m_fall) begin
        m_hold++;
        if (m_hold >= RH) m_reset = 0;
      end
    end
  end

  task automatic check_all();
    int exp_vga;
`ifdef PC_VGA_CLK_EN
    exp_vga = (n / VH) % 2;
`else
    exp_vga = 0;
`endif
    chk("osc",     osc,        (n > 0) && ((n % OD) < OH));
    chk("clk88",   clk88,      ((n / OD) % 3) == 2);
    chk("rise",    clk88_rise, (n > 0) && (n % P == 2 * OD));
    chk("fall",    clk88_fall, (n > 0) && (n % P == 0));
    chk("pclk",    pclk,       (n / P) % 2);
    chk("ready",   ready,      m_ready);
    chk("reset",   reset,      m_reset);
    chk("vga_clk", vga_clk,    exp_vga);
  endtask

  // After release with pwr_good high: first clk88 rise and reset deassertion edges.
  task automatic release_and_measure();
    int rise_at, drop_at;
    rise_at = -1; drop_at = -1;
    pwr_good = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 1; c <= RH * P + 20; c++) begin
      @(negedge clk);
      check_all();
      if (clk88_rise && rise_at < 0) rise_at = c;
      if (!reset && drop_at < 0) drop_at = c;
    end
    chk("first_rise_edge", rise_at, 2 * OD);
    chk("reset_drop_edge", drop_at, RH * P);
  endtask

  task automatic run_random(input int cycles);
    int pg_low;
    pg_low = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      check_all();
      if ($urandom_range(9, 0) == 0) rdy = ~rdy;
      if ($urandom_range(19, 0) == 0) dma = ~dma;
      if (pg_low > 0) begin
        pg_low--;
        pwr_good = (pg_low == 0);
      end else if ($urandom_range(299, 0) == 0) begin
        pg_low   = $urandom_range(15, 1);
        pwr_good = 1'b0;
      end
    end
    pwr_good = 1'b1;
  endtask

  initial begin
    int waited;
    repeat (3) begin
      @(negedge clk);
      check_all();
    end
    chk("reset_held", reset, 1);
    release_and_measure();
    for (int it = 0; it < 3; it++) begin
      run_random(2500);
      waited = 0;
      while (!clk88 && waited < 4 * P) begin
        @(negedge clk);
        waited++;
      end
      chk("found_clk88_high", clk88, 1);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("async_reset_clk88", clk88, 0);
      chk("async_reset_out", reset, 1);
      check_all();
      repeat (4) begin
        @(negedge clk);
        check_all();
      end
      release_and_measure();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
